code_mailbox_fifo: RTL and testbench
====================================

Name: code_mailbox_fifo

Overview:
- Fabric-side producer of the 8-bit status byte that the code-ready input PIO samples. Its status_out drives that PIO's in_port.
- HPS writes an 8-bit game code to a code output PIO, then flips a strobe bit in a strobe output PIO. This block detects the flip and queues the code in a small FIFO.
- The VGA game engine drains the FIFO through a valid/ready interface.
- status_out tells software whether another code can be posted and whether an overflow occurred.

Parameters:
- DEPTH, 4, FIFO entries; legal values 2 or 4. The count field is 3 bits.
- DATA_W, 8, code width; fixed at 8 to match the PIO byte lanes.

Ports:
- clk  in  1  system clock, same domain as the Avalon PIOs.
- reset_n  in  1  reset, asynchronous, active-low. All registers clear on assertion.
- code_in  in  8  code byte from the HPS output PIO. Stable before the strobe flips.
- code_strobe_tgl  in  1  toggle strobe from the HPS. Any level change means "push code_in".
- ovf_clear_tgl  in  1  toggle from the HPS. Any level change clears sticky overflow.
- code_out  out  8  head-of-FIFO code to the game engine.
- code_valid  out  1  head entry valid.
- code_ready  in  1  game engine accepts the head when code_valid and code_ready are both 1.
- status_out  out  8  status byte to the code-ready PIO in_port.

Behaviour:
- Reset values:
  - FIFO empty, count=0, read/write pointers=0.
  - overflow=0, armed=0, toggle history registers=0.
  - code_out=0, code_valid=0, status_out=8'h03.
- Status bit map:
  - [0] space_avail (count<DEPTH)
  - [1] empty (count==0)
  - [4:2] count
  - [5] push_pending
  - [6] 0
  - [7] overflow (sticky)
- Arming:
  - In the first clock after reset release, toggle history registers load the current strobe levels and armed goes to 1.
  - No edge is recognised while armed==0. A strobe left at level 1 across reset therefore never causes a spurious push.
- Edge detect: push_req = armed & (code_strobe_tgl ^ strobe_q). strobe_q updates every cycle. The clear edge is detected the same way.
- Push:
  - In the cycle push_req=1, code_in is written at wptr on the closing rising edge.
  - wptr increments modulo DEPTH; count increments.
  - push_pending=1 during the detect cycle, registered into status.
- Pop:
  - code_valid = (count!=0), registered.
  - When code_valid & code_ready, rptr increments modulo DEPTH and count decrements.
  - code_out shows the new head on the next cycle.
- Simultaneous push and pop:
  - Count unchanged, both pointers advance.
  - When full, the pop frees a slot, so the push is accepted and overflow is not set.
- Push when full with no pop: code_in is dropped, pointers and count are unchanged, and overflow is set to 1.
- Overflow clear: a clear edge sets overflow=0. If a set and a clear occur in the same cycle, set wins.
- Latency:
  - Strobe flip in cycle N → FIFO state updated at the end of N.
  - code_valid and code_out are valid in N+1.
  - status_out reflects the new state in N+2, because status is registered from the FIFO state.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from count, not from pointer compare.
- Reset mid-operation: FIFO contents are discarded and overflow is cleared. The arming sequence repeats, so no edge is recognised in the first post-reset cycle.
- Storage is a register array, not RAM. There is no read-during-write hazard because the head is read from registered state.

Decomposition:
- Shared package code_mailbox_pkg holds:
  - DEPTH default, CNT_W=3.
  - Status bit index constants: ST_SPACE=0, ST_EMPTY=1, ST_CNT_LSB=2, ST_CNT_MSB=4, ST_PEND=5, ST_OVF=7.
  - STATUS_RESET=8'h03.
- Sub-module: toggle_edge_det, containing the history flop, the arming gate and the XOR pulse. It is instantiated twice, for the strobe and the overflow clear.

Test Plan:
- Reset with code_strobe_tgl held at 1, then release → no push; count=0 and status_out=8'h03 in every cycle after release.
- code_in=8'hA5, flip strobe once, code_ready=0 → code_valid=1 and code_out=8'hA5 one cycle later; status_out=8'h05 (count=1, space_avail=1) two cycles later.
- Push 8'h11, 8'h22, 8'h33, 8'h44 (DEPTH=4), then push 8'h55 with code_ready=0 → status_out=8'h90 (overflow=1, count=4, space_avail=0); draining returns 11,22,33,44 in order and 55 never appears.
- FIFO full with code_ready=1 held, flip strobe with code_in=8'h66 in the same cycle as a pop → overflow remains 0, count stays 4, and 66 emerges after the four earlier codes.
- Overflow set, then a clear flip coinciding with another full-FIFO push → overflow stays 1. A later clear flip with no push → status bit7=0 two cycles later.
- Assert reset_n=0 with 3 entries queued and overflow=1 → code_valid=0 and status_out=8'h03 immediately; after release, a strobe flip in the first post-reset cycle is ignored.

Source files
------------

// File: rtl/code_mailbox_pkg.sv
// Shared definitions for the HPS-to-fabric code mailbox.
//   - Default FIFO depth and count width.
//   - Bit positions of the status byte sampled by the code-ready PIO.
//   - Status byte reset value and a helper that packs the status fields.
package code_mailbox_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int CNT_W         = 3;

    localparam int ST_SPACE   = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_CNT_LSB = 2;
    localparam int ST_CNT_MSB = 4;
    localparam int ST_PEND    = 5;
    localparam int ST_OVF     = 7;

    localparam logic [7:0] STATUS_RESET = 8'h03;

    // Bit 6 is reserved and always reads 0.
    function automatic logic [7:0] build_status(
        input logic [CNT_W-1:0] cnt,
        input logic             space_avail,
        input logic             empty,
        input logic             pending,
        input logic             overflow
    );
        logic [7:0] s;
        s                        = '0;
        s[ST_SPACE]              = space_avail;
        s[ST_EMPTY]              = empty;
        s[ST_CNT_MSB:ST_CNT_LSB] = cnt;
        s[ST_PEND]               = pending;
        s[ST_OVF]                = overflow;
        return s;
    endfunction

endpackage

// File: rtl/toggle_edge_det.sv
// Toggle-to-pulse converter for HPS software strobes.
// Any level change of tgl_i produces a one-cycle pulse_o, except in the
// first clock after reset release, where the history flop just captures
// the current level. A toggle held high across reset is thus never
// mistaken for a request.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   tgl_i   - toggle input from a PIO
//   pulse_o - combinational edge pulse, valid in the cycle of the change
module toggle_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic tgl_i,
    output logic pulse_o
);

    logic hist_q;
    logic armed_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            hist_q  <= tgl_i;
            armed_q <= 1'b1;
        end
    end

    assign pulse_o = armed_q & (tgl_i ^ hist_q);

endmodule

// File: rtl/code_mailbox_fifo.sv
// Mailbox carrying game codes from HPS software to the VGA game engine.
// Software writes a code to a PIO and flips a strobe; the flip pushes the
// code into a small register FIFO drained by the engine over valid/ready.
// A registered status byte reports space, empty, count, a push-pending
// flag and a sticky overflow flag back to software.
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   code_in          - code byte from the HPS output PIO
//   code_strobe_tgl  - toggle strobe; each change pushes code_in
//   ovf_clear_tgl    - toggle; each change clears the sticky overflow
//   code_out         - head-of-FIFO code
//   code_valid       - head entry valid
//   code_ready       - engine accepts the head when code_valid is high
//   status_out       - status byte to the code-ready PIO in_port
module code_mailbox_fifo
    import code_mailbox_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] code_in,
    input  logic              code_strobe_tgl,
    input  logic              ovf_clear_tgl,
    output logic [DATA_W-1:0] code_out,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [7:0]        status_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        status_q, status_d;

    logic push_req;
    logic clr_req;
    logic full;
    logic empty;
    logic pop;
    logic push_ok;

    toggle_edge_det u_strobe_det (
        .clk     (clk),
        .reset_n (reset_n),
        .tgl_i   (code_strobe_tgl),
        .pulse_o (push_req)
    );

    toggle_edge_det u_clear_det (
        .clk     (clk),
        .reset_n (reset_n),
        .tgl_i   (ovf_clear_tgl),
        .pulse_o (clr_req)
    );

    always_comb begin
        full    = (cnt_q == CNT_W'(DEPTH));
        empty   = (cnt_q == '0);
        pop     = !empty && code_ready;
        // A pop in the same cycle frees the slot, so a push into a full
        // FIFO is still accepted then.
        push_ok = push_req && (!full || pop);

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;

        if (push_ok) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end

        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // Set has priority over a coincident clear.
        if (clr_req) begin
            ovf_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end

        status_d = build_status(cnt_q, !full, empty, push_req, ovf_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            status_q <= STATUS_RESET;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wptr_q] <= code_in;
        end
    end

    // Head is read from registered state, so a write never races the read.
    assign code_out   = mem_q[rptr_q];
    assign code_valid = (cnt_q != '0);
    assign status_out = status_q;

endmodule

// File: tb/tb_code_mailbox_fifo.sv
module tb_code_mailbox_fifo;

    logic       clk;
    logic       reset_n;
    logic [7:0] code_in;
    logic       code_strobe_tgl;
    logic       ovf_clear_tgl;
    logic [7:0] code_out;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] status_out;

    int errors;
    int checks;

    code_mailbox_fifo #(
        .DEPTH  (4),
        .DATA_W (8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .code_in         (code_in),
        .code_strobe_tgl (code_strobe_tgl),
        .ovf_clear_tgl   (ovf_clear_tgl),
        .code_out        (code_out),
        .code_valid      (code_valid),
        .code_ready      (code_ready),
        .status_out      (status_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each call ends 1 time unit after a rising edge: outputs are settled
    // and new inputs applied here count for the cycle just started.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_code(input logic [7:0] v);
        code_in         = v;
        code_strobe_tgl = ~code_strobe_tgl;
        tick();
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        code_strobe_tgl = 1'b1;
        ovf_clear_tgl   = 1'b0;
        code_in         = 8'h00;
        code_ready      = 1'b0;
        tick();
        tick();
        checks++;
        if (status_out !== 8'h03) begin
            errors++;
            $display("FAIL reset_status: got %h expected %h", status_out, 8'h03);
        end
        checks++;
        if (code_valid !== 1'b0 || code_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b out=%h expected valid=0 out=00",
                     code_valid, code_out);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (status_out !== 8'h03 || code_valid !== 1'b0) begin
                errors++;
                $display("FAIL armed_no_push[%0d]: got status=%h valid=%b expected status=03 valid=0",
                         i, status_out, code_valid);
            end
        end
    endtask

    task automatic test_single_push();
        code_ready = 1'b0;
        push_code(8'hA5);
        checks++;
        if (code_valid !== 1'b1 || code_out !== 8'hA5) begin
            errors++;
            $display("FAIL single_head: got valid=%b out=%h expected valid=1 out=a5",
                     code_valid, code_out);
        end
        checks++;
        if (status_out !== 8'h23) begin
            errors++;
            $display("FAIL single_pending: got %h expected %h", status_out, 8'h23);
        end
        tick();
        checks++;
        if (status_out !== 8'h05) begin
            errors++;
            $display("FAIL single_status: got %h expected %h", status_out, 8'h05);
        end
        code_ready = 1'b1;
        tick();
        code_ready = 1'b0;
        checks++;
        if (code_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop_valid: got %b expected 0", code_valid);
        end
        tick();
        checks++;
        if (status_out !== 8'h03) begin
            errors++;
            $display("FAIL single_empty_status: got %h expected %h", status_out, 8'h03);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h11;
        exp_q[1] = 8'h22;
        exp_q[2] = 8'h33;
        exp_q[3] = 8'h44;
        code_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_code(exp_q[i]);
        end
        push_code(8'h55);
        tick();
        checks++;
        if (status_out !== 8'h90) begin
            errors++;
            $display("FAIL ovf_status: got %h expected %h", status_out, 8'h90);
        end
        code_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (code_valid !== 1'b1 || code_out !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got valid=%b out=%h expected valid=1 out=%h",
                         i, code_valid, code_out, exp_q[i]);
            end
            tick();
        end
        code_ready = 1'b0;
        checks++;
        if (code_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drained_empty: got valid=%b out=%h expected valid=0",
                     code_valid, code_out);
        end
        ovf_clear_tgl = ~ovf_clear_tgl;
        tick();
        tick();
        checks++;
        if (status_out !== 8'h03) begin
            errors++;
            $display("FAIL ovf_cleared: got %h expected %h", status_out, 8'h03);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'hA2;
        exp_q[1] = 8'hA3;
        exp_q[2] = 8'hA4;
        exp_q[3] = 8'h66;
        code_ready = 1'b0;
        push_code(8'hA1);
        push_code(8'hA2);
        push_code(8'hA3);
        push_code(8'hA4);
        checks++;
        if (code_out !== 8'hA1) begin
            errors++;
            $display("FAIL full_head: got %h expected %h", code_out, 8'hA1);
        end
        code_ready = 1'b1;
        push_code(8'h66);
        code_ready = 1'b0;
        tick();
        checks++;
        if (status_out !== 8'h10) begin
            errors++;
            $display("FAIL full_pushpop_status: got %h expected %h", status_out, 8'h10);
        end
        code_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (code_valid !== 1'b1 || code_out !== exp_q[i]) begin
                errors++;
                $display("FAIL pushpop_drain[%0d]: got valid=%b out=%h expected valid=1 out=%h",
                         i, code_valid, code_out, exp_q[i]);
            end
            tick();
        end
        code_ready = 1'b0;
        checks++;
        if (code_valid !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_empty: got valid=%b expected 0", code_valid);
        end
    endtask

    task automatic test_ovf_clear_race();
        code_ready = 1'b0;
        push_code(8'hB1);
        push_code(8'hB2);
        push_code(8'hB3);
        push_code(8'hB4);
        push_code(8'hB5);
        // Clear edge coincides with another rejected push: set must win.
        ovf_clear_tgl = ~ovf_clear_tgl;
        push_code(8'hB6);
        tick();
        checks++;
        if (status_out !== 8'h90) begin
            errors++;
            $display("FAIL race_set_wins: got %h expected %h", status_out, 8'h90);
        end
        ovf_clear_tgl = ~ovf_clear_tgl;
        tick();
        tick();
        checks++;
        if (status_out !== 8'h10) begin
            errors++;
            $display("FAIL race_later_clear: got %h expected %h", status_out, 8'h10);
        end
        checks++;
        if (code_out !== 8'hB1) begin
            errors++;
            $display("FAIL race_head: got %h expected %h", code_out, 8'hB1);
        end
    endtask

    task automatic test_reset_mid_op();
        code_ready = 1'b0;
        push_code(8'hC0);
        code_ready = 1'b1;
        tick();
        code_ready = 1'b0;
        tick();
        checks++;
        if (status_out !== 8'h8D || code_out !== 8'hB2) begin
            errors++;
            $display("FAIL pre_reset_state: got status=%h out=%h expected status=8d out=b2",
                     status_out, code_out);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (code_valid !== 1'b0 || status_out !== 8'h03 || code_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got valid=%b status=%h out=%h expected valid=0 status=03 out=00",
                     code_valid, status_out, code_out);
        end
        tick();
        reset_n         = 1'b1;
        code_in         = 8'hD1;
        code_strobe_tgl = ~code_strobe_tgl;
        tick();
        tick();
        checks++;
        if (code_valid !== 1'b0 || status_out !== 8'h03) begin
            errors++;
            $display("FAIL post_reset_ignored: got valid=%b status=%h expected valid=0 status=03",
                     code_valid, status_out);
        end
        push_code(8'h77);
        checks++;
        if (code_valid !== 1'b1 || code_out !== 8'h77) begin
            errors++;
            $display("FAIL post_reset_push: got valid=%b out=%h expected valid=1 out=77",
                     code_valid, code_out);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_push();
        test_overflow();
        test_full_push_pop();
        test_ovf_clear_race();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
